// File: rtl/interrupt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer_pkg
// Purpose  : Shared types and constants for the interrupt sequencer: FSM state
//            encoding, default source count and the handler vector table.
// Revision : 1.0 - initial release
// ============================================================================
package interrupt_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int VEC_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ENTRY = 2'd2
  } state_t;

  localparam logic [VEC_W-1:0] VEC_BIT0 = 10'h3FC;
  localparam logic [VEC_W-1:0] VEC_BIT1 = 10'h201;
  localparam logic [VEC_W-1:0] VEC_BIT2 = 10'h215;
  localparam logic [VEC_W-1:0] VEC_BIT3 = 10'h229;
  localparam logic [VEC_W-1:0] VEC_BIT4 = 10'h23D;
  localparam logic [VEC_W-1:0] VEC_BIT5 = 10'h265;
  localparam logic [VEC_W-1:0] VEC_BIT6 = 10'h279;
  localparam logic [VEC_W-1:0] VEC_BIT7 = 10'h28D;

  // Handler address for a source index; sources without a table entry map to 0
  function automatic logic [VEC_W-1:0] vec_of(input int idx);
    case (idx)
      0:       vec_of = VEC_BIT0;
      1:       vec_of = VEC_BIT1;
      2:       vec_of = VEC_BIT2;
      3:       vec_of = VEC_BIT3;
      4:       vec_of = VEC_BIT4;
      5:       vec_of = VEC_BIT5;
      6:       vec_of = VEC_BIT6;
      7:       vec_of = VEC_BIT7;
      default: vec_of = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_sequencer_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : priority_pick
// Purpose  : One-hot selector of the lowest-index set request bit (zero when
//            no bit is set).
// Revision : 1.0 - initial release
// ============================================================================
module priority_pick #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Two's-complement trick isolates the least significant set bit
  assign grant = req & (~req + WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer
// Purpose  : Prioritised, nestable interrupt sequencer. Latches rising edges
//            of the interrupt lines, offers the highest-priority enabled
//            request that may pre-empt the current service level, and hands
//            the CPU a registered handler vector on acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  int_e,
  input  logic              mask_we,
  input  logic [WIDTH-1:0]  mask_d,
  input  logic              ack,
  input  logic              reti,
  output logic              irq,
  output logic [VEC_W-1:0]  vector,
  output logic              vector_valid,
  output logic [WIDTH-1:0]  pending,
  output logic [WIDTH-1:0]  in_service,
  output logic [WIDTH-1:0]  mask_q
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   int_q;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic [WIDTH-1:0]   in_service_q, in_service_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic               irq_q, irq_d;
  logic               vector_valid_q, vector_valid_d;

  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   isv_low;
  logic [WIDTH-1:0]   higher_mask;
  logic [WIDTH-1:0]   eligible;
  logic [WIDTH-1:0]   sel;
  logic [VEC_W-1:0]   vec_sel;
  logic               accept;

  // Current service level: lowest-index in-service bit, also the reti target
  priority_pick #(.WIDTH(WIDTH)) u_pick_isv (
    .req   (in_service_q),
    .grant (isv_low)
  );

  // Offer candidate: lowest-index eligible request
  priority_pick #(.WIDTH(WIDTH)) u_pick_sel (
    .req   (eligible),
    .grant (sel)
  );

  // Eligibility, FSM next state and next values of every register
  always_comb begin
    rise = int_e & ~int_q;

    // Only sources strictly above the current service level may pre-empt it
    if (isv_low == '0) higher_mask = '1;
    else               higher_mask = isv_low - WIDTH'(1);
    eligible = pending_q & mask_q & higher_mask;

    vec_sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) vec_sel = vec_sel | vec_of(i);
    end

    // An ack only counts while an offer is actually on the table
    accept = (state_q == ST_REQ) && ack && (sel != '0);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (eligible != '0) state_d = ST_REQ;
      ST_REQ: begin
        if (accept)               state_d = ST_ENTRY;
        else if (eligible == '0)  state_d = ST_IDLE;
      end
      ST_ENTRY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    irq_d          = (state_d == ST_REQ);
    vector_valid_d = accept;
    vector_d       = accept ? vec_sel : vector_q;

    // A fresh rise wins over the clear of the same bit
    pending_d = (pending_q & ~(accept ? sel : '0)) | rise;

    // reti pops the pre-ack service level, then the accepted source is pushed
    in_service_d = (in_service_q & ~(reti ? isv_low : '0)) | (accept ? sel : '0);
  end

  // State and output registers; int_q tracks the lines during reset so a line
  // already high when reset releases is not seen as a new edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      int_q          <= int_e;
      pending_q      <= '0;
      in_service_q   <= '0;
      mask_q         <= '0;
      vector_q       <= '0;
      irq_q          <= 1'b0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      int_q          <= int_e;
      pending_q      <= pending_d;
      in_service_q   <= in_service_d;
      mask_q         <= mask_we ? mask_d : mask_q;
      vector_q       <= vector_d;
      irq_q          <= irq_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign irq          = irq_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign pending      = pending_q;
  assign in_service   = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_sequencer
// Purpose  : Directed self-checking bench for interrupt_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] int_e;
  logic       mask_we;
  logic [7:0] mask_d;
  logic       ack;
  logic       reti;
  logic       irq;
  logic [9:0] vector;
  logic       vector_valid;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] mask_q;

  int n_assert = 0;
  int n_fail   = 0;

  interrupt_sequencer #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .int_e        (int_e),
    .mask_we      (mask_we),
    .mask_d       (mask_d),
    .ack          (ack),
    .reti         (reti),
    .irq          (irq),
    .vector       (vector),
    .vector_valid (vector_valid),
    .pending      (pending),
    .in_service   (in_service),
    .mask_q       (mask_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; int_e = 8'h80; mask_we = 1'b0; mask_d = 8'h00; ack = 1'b0; reti = 1'b0;
    step(); step();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_vv", {31'd0, vector_valid}, 32'd0);
    chk("rst_vector", {22'd0, vector}, 32'h0);
    chk("rst_pending", {24'd0, pending}, 32'h0);
    chk("rst_in_service", {24'd0, in_service}, 32'h0);
    chk("rst_mask", {24'd0, mask_q}, 32'h0);

    // Line high through reset must not look like a rise
    reset = 1'b1;
    step();
    chk("no_rise_after_rst", {24'd0, pending}, 32'h0);

    // Single source, basic flow
    int_e = 8'h00; mask_we = 1'b1; mask_d = 8'hFF;
    step();
    mask_we = 1'b0;
    chk("mask_ff", {24'd0, mask_q}, 32'hFF);
    int_e = 8'h04;
    step();
    chk("t1_pending", {24'd0, pending}, 32'h04);
    chk("t1_irq_lat0", {31'd0, irq}, 32'd0);
    int_e = 8'h00;
    step();
    chk("t1_irq", {31'd0, irq}, 32'd1);
    chk("t1_vv_pre", {31'd0, vector_valid}, 32'd0);
    ack = 1'b1;
    step();
    chk("t1_vector", {22'd0, vector}, 32'h215);
    chk("t1_vv", {31'd0, vector_valid}, 32'd1);
    chk("t1_isv", {24'd0, in_service}, 32'h04);
    chk("t1_pending_clr", {24'd0, pending}, 32'h00);
    chk("t1_irq_entry", {31'd0, irq}, 32'd0);
    ack = 1'b0;
    step();
    chk("t1_vv_drop", {31'd0, vector_valid}, 32'd0);
    chk("t1_vector_hold", {22'd0, vector}, 32'h215);
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("t1_reti", {24'd0, in_service}, 32'h00);

    // Two simultaneous rises; lower priority blocked until reti
    int_e = 8'h22;
    step();
    chk("t2_pending", {24'd0, pending}, 32'h22);
    int_e = 8'h00;
    step();
    chk("t2_irq", {31'd0, irq}, 32'd1);
    ack = 1'b1;
    step();
    chk("t2_vector_b1", {22'd0, vector}, 32'h201);
    chk("t2_isv", {24'd0, in_service}, 32'h02);
    chk("t2_pending", {24'd0, pending}, 32'h20);
    ack = 1'b0;
    step(); step();
    chk("t2_blocked_irq", {31'd0, irq}, 32'd0);
    chk("t2_blocked_pend", {24'd0, pending}, 32'h20);
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("t2_reti", {24'd0, in_service}, 32'h00);
    step();
    chk("t2_irq_b5", {31'd0, irq}, 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t2_vector_b5", {22'd0, vector}, 32'h265);
    chk("t2_isv_b5", {24'd0, in_service}, 32'h20);
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("t2_reti_b5", {24'd0, in_service}, 32'h00);

    // Nesting: bit0 pre-empts bit3
    int_e = 8'h08;
    step();
    int_e = 8'h00;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_vector_b3", {22'd0, vector}, 32'h229);
    chk("t3_isv_b3", {24'd0, in_service}, 32'h08);
    step();
    int_e = 8'h01;
    step();
    int_e = 8'h00;
    step();
    chk("t3_irq_nest", {31'd0, irq}, 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_vector_b0", {22'd0, vector}, 32'h3FC);
    chk("t3_isv_nest", {24'd0, in_service}, 32'h09);
    reti = 1'b1;
    step();
    chk("t3_reti1", {24'd0, in_service}, 32'h08);
    step();
    reti = 1'b0;
    chk("t3_reti2", {24'd0, in_service}, 32'h00);

    // Masked request stays pending until enabled
    mask_we = 1'b1; mask_d = 8'h00;
    step();
    mask_we = 1'b0;
    int_e = 8'h08;
    step();
    int_e = 8'h00;
    chk("t4_pending", {24'd0, pending}, 32'h08);
    step(); step();
    chk("t4_irq_masked", {31'd0, irq}, 32'd0);
    mask_we = 1'b1; mask_d = 8'h08;
    step();
    mask_we = 1'b0;
    chk("t4_mask", {24'd0, mask_q}, 32'h08);
    step();
    chk("t4_irq_unmask", {31'd0, irq}, 32'd1);

    // Mask cleared while offering: withdraw, pending kept
    mask_we = 1'b1; mask_d = 8'h00;
    step();
    mask_we = 1'b0;
    step();
    chk("t5_irq_withdraw", {31'd0, irq}, 32'd0);
    chk("t5_pending_kept", {24'd0, pending}, 32'h08);

    // Reset in ENTRY clears everything
    mask_we = 1'b1; mask_d = 8'hFF;
    step();
    mask_we = 1'b0;
    step();
    ack = 1'b1;
    step();
    chk("t5_vv_pre_rst", {31'd0, vector_valid}, 32'd1);
    ack = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t5_rst_vv", {31'd0, vector_valid}, 32'd0);
    chk("t5_rst_vector", {22'd0, vector}, 32'h0);
    chk("t5_rst_isv", {24'd0, in_service}, 32'h00);
    chk("t5_rst_mask", {24'd0, mask_q}, 32'h00);
    chk("t5_rst_irq", {31'd0, irq}, 32'd0);

    // reti with nothing in service
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("t6_reti_empty", {24'd0, in_service}, 32'h00);

    // reti and ack together
    mask_we = 1'b1; mask_d = 8'hFF;
    step();
    mask_we = 1'b0;
    int_e = 8'h02;
    step();
    int_e = 8'h00;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t6_isv_b1", {24'd0, in_service}, 32'h02);
    step();
    int_e = 8'h01;
    step();
    int_e = 8'h00;
    step();
    chk("t6_irq_b0", {31'd0, irq}, 32'd1);
    ack = 1'b1; reti = 1'b1;
    step();
    ack = 1'b0; reti = 1'b0;
    chk("t6_isv_swap", {24'd0, in_service}, 32'h01);
    chk("t6_vector", {22'd0, vector}, 32'h3FC);
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("t6_isv_clear", {24'd0, in_service}, 32'h00);

    // Higher-priority arrival replaces the offer while in REQ
    int_e = 8'h08;
    step();
    int_e = 8'h00;
    step();
    chk("t7_irq_b3", {31'd0, irq}, 32'd1);
    int_e = 8'h02;
    step();
    int_e = 8'h00;
    chk("t7_pending", {24'd0, pending}, 32'h0A);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t7_vector_replaced", {22'd0, vector}, 32'h201);
    chk("t7_isv", {24'd0, in_service}, 32'h02);
    chk("t7_pending_left", {24'd0, pending}, 32'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
